// File: rtl/spi_slave_driver_if.sv
// Signal bundle between an SPI master / word buffer and spi_slave_driver.
// The slave modport is the driver's view; master is the view of whatever drives it.
interface spi_slave_driver_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  ready;
   logic                  sclk;
   logic                  cs;
   logic                  mosi;
   logic                  miso;

   modport slave (
      input  data_in, sclk, cs, mosi,
      output data_out, ready, miso
   );

   modport master (
      output data_in, sclk, cs, mosi,
      input  data_out, ready, miso
   );
endinterface

// File: rtl/spi_slave_driver.sv
// SPI mode-0 slave physical stage, fully oversampled in the clk domain.
// Optional SPI_MISO_TRISTATE_EN: miso floats while deselected or idle.
module spi_slave_driver #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic             clk,
   input logic             rst,
   spi_slave_driver_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_prev_q;
   logic                   cs_prev_q;

   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sclk_rise;
   logic                   sclk_fall;
   logic                   cs_rise;
   logic                   cs_fall;

   state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  rx_q, rx_d;
   logic [DATA_WIDTH-1:0]  tx_q, tx_d;
   logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [1:0]             rdy_cnt_q, rdy_cnt_d;
   logic                   byte_done_q, byte_done_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rx_q        <= '0;
         tx_q        <= '0;
         data_out_q  <= '0;
         cnt_q       <= '0;
         rdy_cnt_q   <= '0;
         byte_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         data_out_q  <= data_out_d;
         cnt_q       <= cnt_d;
         rdy_cnt_q   <= rdy_cnt_d;
         byte_done_q <= byte_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      data_out_d  = data_out_q;
      cnt_d       = cnt_q;
      rdy_cnt_d   = rdy_cnt_q;
      byte_done_d = byte_done_q;

      // Completion is state-independent so a byte finished together with cs rising still publishes from IDLE.
      if (cnt_q == CNT_W'(DATA_WIDTH)) begin
         data_out_d  = rx_q;
         cnt_d       = '0;
         byte_done_d = 1'b1;
         rdy_cnt_d   = 2'd2;
      end else if (rdy_cnt_q != 2'd0) begin
         rdy_cnt_d = rdy_cnt_q - 2'd1;
      end

      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d     = SHIFT;
               tx_d        = bus.data_in;
               byte_done_d = 1'b0;
            end
         end
         SHIFT: begin
            if (sclk_rise) begin
               rx_d  = {rx_q[DATA_WIDTH-2:0], mosi_s};
               cnt_d = cnt_q + CNT_W'(1);
            end else if (sclk_fall) begin
               if (byte_done_q) begin
                  tx_d        = bus.data_in;
                  byte_done_d = 1'b0;
               end else begin
                  tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
               end
            end
            if (cs_rise) begin
               state_d = IDLE;
               if (cnt_d != CNT_W'(DATA_WIDTH)) begin
                  cnt_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.data_out = data_out_q;
   assign bus.ready    = (rdy_cnt_q != 2'd0);

`ifdef SPI_MISO_TRISTATE_EN
   assign bus.miso = (state_q == SHIFT && !cs_s) ? tx_q[DATA_WIDTH-1] : 1'bz;
`else
   assign bus.miso = (state_q == SHIFT && !cs_s) ? tx_q[DATA_WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_driver.sv
// Self-checking bench for spi_slave_driver: table-driven frames plus corner sequences,
// with received bytes checked through a scoreboard queue at each ready window.
module tb_spi_slave_driver;

   localparam int unsigned DW   = 8;
   localparam int unsigned SYNC = 2;
   localparam int unsigned HALF = 8;
   localparam int unsigned NV   = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned cyc = 0;
   int unsigned last_rise_cyc = 0;
   int n_vec = 0;
   int n_err = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_sent = '0;
   logic idle_miso;

   typedef struct {
      logic [7:0] mosi;
      logic [7:0] din;
      logic       first;
      logic       last;
   } vec_t;

   vec_t vecs[NV];

   spi_slave_driver_if #(.DATA_WIDTH(DW)) bus ();

   spi_slave_driver #(
      .DATA_WIDTH(DW),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_clk(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Each ready window: pop expected byte, check value, latency, stability and width.
   task automatic monitor();
      int unsigned hi = 0;
      logic [DW-1:0] cur = '0;
      forever begin
         @(negedge clk);
         if (bus.ready === 1'b1) begin
            if (hi == 0) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_ready", 32'(bus.data_out), 32'hFFFF_FFFF);
               end else begin
                  cur = exp_q.pop_front();
                  chk("data_out", 32'(bus.data_out), 32'(cur));
                  chk("ready_latency", cyc - last_rise_cyc, SYNC + 2);
               end
            end else begin
               chk("data_out_stable", 32'(bus.data_out), 32'(cur));
            end
            hi++;
         end else if (hi != 0) begin
            chk("ready_width", hi, 2);
            hi = 0;
         end
      end
   endtask

   task automatic sclk_bit(input logic b, output logic m);
      bus.mosi = b;
      wait_clk(HALF);
      bus.sclk = 1'b1;
      last_rise_cyc = cyc;
      m = bus.miso;
      wait_clk(HALF);
      bus.sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic [7:0] din_next, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         bus.mosi = b[i];
         wait_clk(HALF);
         bus.sclk = 1'b1;
         last_rise_cyc = cyc;
         rx[i] = bus.miso;
         if (i == 0) begin
            exp_q.push_back(b);
            last_sent = b;
            wait_clk(4);
            bus.data_in = din_next;
            wait_clk(HALF - 4);
         end else begin
            wait_clk(HALF);
         end
         bus.sclk = 1'b0;
      end
   endtask

   task automatic run_vec(input int unsigned i);
      logic [7:0] rx;
      logic [7:0] nxt;
      nxt = vecs[i].din;
      if (!vecs[i].last && (i + 1 < NV)) nxt = vecs[i+1].din;
      if (vecs[i].first) begin
         bus.data_in = vecs[i].din;
         bus.cs = 1'b0;
         wait_clk(8);
      end
      send_byte(vecs[i].mosi, nxt, rx);
      chk($sformatf("miso_byte[%0d]", i), 32'(rx), 32'(vecs[i].din));
      if (vecs[i].last) begin
         wait_clk(HALF);
         bus.cs = 1'b1;
         wait_clk(12);
      end
   endtask

   initial begin
      logic [7:0] rx;
      logic [7:0] pat;
      logic m;
`ifdef SPI_MISO_TRISTATE_EN
      idle_miso = 1'bz;
`else
      idle_miso = 1'b0;
`endif
      bus.sclk = 1'b0;
      bus.cs = 1'b1;
      bus.mosi = 1'b0;
      bus.data_in = '0;
      vecs[0] = '{mosi: 8'hA5, din: 8'h3C, first: 1'b1, last: 1'b1};
      vecs[1] = '{mosi: 8'h01, din: 8'h3C, first: 1'b1, last: 1'b0};
      vecs[2] = '{mosi: 8'h80, din: 8'h11, first: 1'b0, last: 1'b0};
      vecs[3] = '{mosi: 8'hFF, din: 8'h22, first: 1'b0, last: 1'b1};
      vecs[4] = '{mosi: 8'h00, din: 8'hFF, first: 1'b1, last: 1'b1};
      vecs[5] = '{mosi: 8'h96, din: 8'h69, first: 1'b1, last: 1'b1};

      #2 rst = 1'b0;
      fork
         monitor();
      join_none
      wait_clk(3);
      chk("reset_data_out", 32'(bus.data_out), 32'h0);
      chk("reset_ready", 32'(bus.ready), 32'h0);
      chk("reset_miso", 32'(bus.miso), 32'(idle_miso));
      rst = 1'b1;
      wait_clk(10);
      chk("idle_miso_cs_high", 32'(bus.miso), 32'(idle_miso));

      for (int unsigned i = 0; i < NV; i++) run_vec(i);

      // Aborted frame after 5 bits, then a clean frame from bit 0.
      bus.data_in = 8'h77;
      bus.cs = 1'b0;
      wait_clk(8);
      pat = 8'hB7;
      for (int i = 7; i >= 3; i--) sclk_bit(pat[i], m);
      wait_clk(HALF);
      bus.cs = 1'b1;
      wait_clk(20);
      chk("abort_data_out", 32'(bus.data_out), 32'(last_sent));
      chk("abort_ready", 32'(bus.ready), 32'h0);
      bus.data_in = 8'hC3;
      bus.cs = 1'b0;
      wait_clk(8);
      send_byte(8'h5A, 8'hC3, rx);
      chk("miso_after_abort", 32'(rx), 32'hC3);
      wait_clk(HALF);
      bus.cs = 1'b1;
      wait_clk(12);

      // cs rises on the same cycle as the last sclk rise.
      bus.data_in = 8'hE1;
      bus.cs = 1'b0;
      wait_clk(8);
      pat = 8'h4B;
      for (int i = 7; i >= 1; i--) begin
         sclk_bit(pat[i], m);
         rx[i] = m;
      end
      bus.mosi = pat[0];
      wait_clk(HALF);
      bus.sclk = 1'b1;
      bus.cs = 1'b1;
      last_rise_cyc = cyc;
      rx[0] = bus.miso;
      exp_q.push_back(pat);
      last_sent = pat;
      wait_clk(HALF);
      bus.sclk = 1'b0;
      chk("miso_cs_coincident", 32'(rx), 32'hE1);
      wait_clk(10);
      chk("idle_miso_after_frame", 32'(bus.miso), 32'(idle_miso));

      // Asynchronous reset in the middle of a byte.
      bus.data_in = 8'h99;
      bus.cs = 1'b0;
      wait_clk(8);
      for (int i = 0; i < 3; i++) sclk_bit(1'b1, m);
      bus.sclk = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      #1;
      chk("midreset_data_out", 32'(bus.data_out), 32'h0);
      chk("midreset_ready", 32'(bus.ready), 32'h0);
      chk("midreset_miso", 32'(bus.miso), 32'(idle_miso));
      bus.sclk = 1'b0;
      bus.cs = 1'b1;
      wait_clk(4);
      rst = 1'b1;
      last_sent = '0;
      wait_clk(30);
      chk("post_reset_data_out", 32'(bus.data_out), 32'(last_sent));
      chk("post_reset_ready", 32'(bus.ready), 32'h0);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
